// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared widths, control bundle bit map and forwarding encodings
// Purpose: constants shared by the ID/EX stage, its forwarding helper and the bus interface.
// Ports: none (package).
package core_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 8;

  // Control bundle bit map. ALUOp occupies [CTRL_ALUOP_MSB:CTRL_ALUOP_LSB].
  localparam int CTRL_REGWRITE  = 0;
  localparam int CTRL_MEMREAD   = 1;
  localparam int CTRL_MEMWRITE  = 2;
  localparam int CTRL_MEMTOREG  = 3;
  localparam int CTRL_ALUSRC    = 4;
  localparam int CTRL_ALUOP_LSB = 5;
  localparam int CTRL_ALUOP_MSB = 7;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF    = 2'b00;
  localparam fwd_sel_t FWD_EXMEM = 2'b10;
  localparam fwd_sel_t FWD_MEMWB = 2'b01;

endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - decode-to-execute bus between ID logic and the ID/EX register
// Purpose: bundles ID-stage operands/control, EX/MEM producer info and ID/EX outputs.
// Ports: none; modport slave is the ID/EX register, modport master is the ID-side driver.
interface id_ex_stage_if;
  import core_pkg::*;

  logic              freeze_i;
  logic              flush_i;
  logic [DATA_W-1:0] pc_i;
  logic [DATA_W-1:0] rs1_data_i;
  logic [DATA_W-1:0] rs2_data_i;
  logic [DATA_W-1:0] imm_i;
  logic [REG_AW-1:0] rs1_addr_i;
  logic [REG_AW-1:0] rs2_addr_i;
  logic [REG_AW-1:0] rd_addr_i;
  logic              use_rs1_i;
  logic              use_rs2_i;
  logic [CTRL_W-1:0] ctrl_i;
  logic [REG_AW-1:0] exmem_rd_i;
  logic              exmem_regwrite_i;

  logic [DATA_W-1:0] pc_o;
  logic [DATA_W-1:0] rs1_data_o;
  logic [DATA_W-1:0] rs2_data_o;
  logic [DATA_W-1:0] imm_o;
  logic [REG_AW-1:0] rs1_addr_o;
  logic [REG_AW-1:0] rs2_addr_o;
  logic [REG_AW-1:0] rd_addr_o;
  logic [CTRL_W-1:0] ctrl_o;
  fwd_sel_t          fwd_a_o;
  fwd_sel_t          fwd_b_o;
  logic              stall_o;

  modport slave (
    input  freeze_i, flush_i, pc_i, rs1_data_i, rs2_data_i, imm_i,
    input  rs1_addr_i, rs2_addr_i, rd_addr_i, use_rs1_i, use_rs2_i, ctrl_i,
    input  exmem_rd_i, exmem_regwrite_i,
    output pc_o, rs1_data_o, rs2_data_o, imm_o, rs1_addr_o, rs2_addr_o, rd_addr_o,
    output ctrl_o, fwd_a_o, fwd_b_o, stall_o
  );

  modport master (
    output freeze_i, flush_i, pc_i, rs1_data_i, rs2_data_i, imm_i,
    output rs1_addr_i, rs2_addr_i, rd_addr_i, use_rs1_i, use_rs2_i, ctrl_i,
    output exmem_rd_i, exmem_regwrite_i,
    input  pc_o, rs1_data_o, rs2_data_o, imm_o, rs1_addr_o, rs2_addr_o, rd_addr_o,
    input  ctrl_o, fwd_a_o, fwd_b_o, stall_o
  );

endinterface

// File: rtl/fwd_precompute.sv
// rtl/fwd_precompute.sv - forwarding select for one EX operand, evaluated in ID
// Purpose: picks the nearest in-flight producer of a source register for next cycle's EX.
// Ports: src_addr_i/use_i (ID source), idex_rd_i/idex_regwrite_i (producer now in EX),
//        exmem_rd_i/exmem_regwrite_i (producer now in MEM), fwd_o (2-bit select).
module fwd_precompute
  import core_pkg::*;
(
  input  logic [REG_AW-1:0] src_addr_i,
  input  logic              use_i,
  input  logic [REG_AW-1:0] idex_rd_i,
  input  logic              idex_regwrite_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic              exmem_regwrite_i,
  output fwd_sel_t          fwd_o
);

  logic w_hit_idex;
  logic w_hit_exmem;

  // Whatever sits in EX now is in EX/MEM when this consumer reaches EX,
  // and EX/MEM now becomes MEM/WB; x0 is hardwired and never forwarded.
  assign w_hit_idex  = use_i && idex_regwrite_i && (idex_rd_i != '0)
                       && (idex_rd_i == src_addr_i);
  assign w_hit_exmem = use_i && exmem_regwrite_i && (exmem_rd_i != '0)
                       && (exmem_rd_i == src_addr_i);

  always_comb begin
    fwd_o = FWD_RF;
    if (w_hit_idex) begin
      fwd_o = FWD_EXMEM;
    end else if (w_hit_exmem) begin
      fwd_o = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with forwarding precompute and load-use stall
// Purpose: latches decode operands/control, registers EX forwarding selects, raises load-use stall.
// Ports: clk_i, rst_i (sync, active-high); bus (slave modport) carrying freeze/flush,
//        ID operands and control, EX/MEM producer info, registered outputs and stall_o.
module id_ex_stage
  import core_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  id_ex_stage_if.slave    bus
);

  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_rs1_data;
  logic [DATA_W-1:0] r_rs2_data;
  logic [DATA_W-1:0] r_imm;
  logic [REG_AW-1:0] r_rs1_addr;
  logic [REG_AW-1:0] r_rs2_addr;
  logic [REG_AW-1:0] r_rd_addr;
  logic [CTRL_W-1:0] r_ctrl;
  fwd_sel_t          r_fwd_a;
  fwd_sel_t          r_fwd_b;

  fwd_sel_t          w_fwd_a;
  fwd_sel_t          w_fwd_b;
  logic              w_load_in_ex;
  logic              w_stall;
  logic              w_bubble;

  fwd_precompute u_fwd_a (
    .src_addr_i       (bus.rs1_addr_i),
    .use_i            (bus.use_rs1_i),
    .idex_rd_i        (r_rd_addr),
    .idex_regwrite_i  (r_ctrl[CTRL_REGWRITE]),
    .exmem_rd_i       (bus.exmem_rd_i),
    .exmem_regwrite_i (bus.exmem_regwrite_i),
    .fwd_o            (w_fwd_a)
  );

  fwd_precompute u_fwd_b (
    .src_addr_i       (bus.rs2_addr_i),
    .use_i            (bus.use_rs2_i),
    .idex_rd_i        (r_rd_addr),
    .idex_regwrite_i  (r_ctrl[CTRL_REGWRITE]),
    .exmem_rd_i       (bus.exmem_rd_i),
    .exmem_regwrite_i (bus.exmem_regwrite_i),
    .fwd_o            (w_fwd_b)
  );

  // A load in EX has no data until after MEM, so a dependent ID instruction
  // must wait one cycle; it then sees the load in EX/MEM and takes MEM/WB.
  assign w_load_in_ex = r_ctrl[CTRL_MEMREAD] && r_ctrl[CTRL_REGWRITE] && (r_rd_addr != '0);
  assign w_stall      = w_load_in_ex
                        && ((bus.use_rs1_i && (bus.rs1_addr_i == r_rd_addr))
                         || (bus.use_rs2_i && (bus.rs2_addr_i == r_rd_addr)));
  assign w_bubble     = bus.flush_i || w_stall;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1_addr <= '0;
      r_rs2_addr <= '0;
      r_rd_addr  <= '0;
      r_ctrl     <= '0;
      r_fwd_a    <= FWD_RF;
      r_fwd_b    <= FWD_RF;
    end else if (!bus.freeze_i) begin
      // Data and source indices are don't-care under a bubble, so they
      // always capture; only control, rd and selects are squashed.
      r_pc       <= bus.pc_i;
      r_rs1_data <= bus.rs1_data_i;
      r_rs2_data <= bus.rs2_data_i;
      r_imm      <= bus.imm_i;
      r_rs1_addr <= bus.rs1_addr_i;
      r_rs2_addr <= bus.rs2_addr_i;
      if (w_bubble) begin
        r_rd_addr <= '0;
        r_ctrl    <= '0;
        r_fwd_a   <= FWD_RF;
        r_fwd_b   <= FWD_RF;
      end else begin
        r_rd_addr <= bus.rd_addr_i;
        r_ctrl    <= bus.ctrl_i;
        r_fwd_a   <= w_fwd_a;
        r_fwd_b   <= w_fwd_b;
      end
    end
  end

  assign bus.pc_o       = r_pc;
  assign bus.rs1_data_o = r_rs1_data;
  assign bus.rs2_data_o = r_rs2_data;
  assign bus.imm_o      = r_imm;
  assign bus.rs1_addr_o = r_rs1_addr;
  assign bus.rs2_addr_o = r_rs2_addr;
  assign bus.rd_addr_o  = r_rd_addr;
  assign bus.ctrl_o     = r_ctrl;
  assign bus.fwd_a_o    = r_fwd_a;
  assign bus.fwd_b_o    = r_fwd_b;
  assign bus.stall_o    = w_stall;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for the ID/EX stage
module tb_id_ex_stage;

  localparam logic [7:0] ALU = 8'h41;
  localparam logic [7:0] LW  = 8'h1B;

  typedef struct packed {
    logic        chk_pc;
    logic [7:0]  ctrl;
    logic [4:0]  rd;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] pc;
  } exp_t;

  typedef struct packed {
    logic        rst;
    logic        fr;
    logic        fl;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        u1;
    logic        u2;
    logic [7:0]  ctrl;
    logic [4:0]  xrd;
    logic        xrw;
    logic        st;
    exp_t        e;
  } stim_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vecs = 0;
  int   fails = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  id_ex_stage_if bus ();

  id_ex_stage u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  function automatic stim_t mk(input logic r, input logic fr, input logic fl,
                               input logic [31:0] pc, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [4:0] rd,
                               input logic u1, input logic u2, input logic [7:0] ctrl,
                               input logic [4:0] xrd, input logic xrw, input logic st,
                               input logic chk, input logic [7:0] ectrl,
                               input logic [4:0] erd, input logic [1:0] fa,
                               input logic [1:0] fb, input logic [31:0] epc);
    stim_t s;
    s.rst = r; s.fr = fr; s.fl = fl; s.pc = pc; s.rs1 = rs1; s.rs2 = rs2; s.rd = rd;
    s.u1 = u1; s.u2 = u2; s.ctrl = ctrl; s.xrd = xrd; s.xrw = xrw; s.st = st;
    s.e.chk_pc = chk; s.e.ctrl = ectrl; s.e.rd = erd; s.e.fa = fa; s.e.fb = fb; s.e.pc = epc;
    return s;
  endfunction

  // Reset row: arbitrary inputs, everything clears, prior stall is don't-care.
  function automatic stim_t rst_row();
    return mk(1, 0, 0, 32'hDEAD_BEEF, 7, 8, 9, 1, 1, 8'hFF, 5, 1, 1'bx,
              1, 8'h00, 0, 2'b00, 2'b00, 32'h0);
  endfunction

  task automatic apply(input stim_t s);
    rst                  = s.rst;
    bus.freeze_i         = s.fr;
    bus.flush_i          = s.fl;
    bus.pc_i             = s.pc;
    bus.rs1_data_i       = s.pc ^ 32'h1111_0000;
    bus.rs2_data_i       = s.pc ^ 32'h0000_2222;
    bus.imm_i            = ~s.pc;
    bus.rs1_addr_i       = s.rs1;
    bus.rs2_addr_i       = s.rs2;
    bus.rd_addr_i        = s.rd;
    bus.use_rs1_i        = s.u1;
    bus.use_rs2_i        = s.u2;
    bus.ctrl_i           = s.ctrl;
    bus.exmem_rd_i       = s.xrd;
    bus.exmem_regwrite_i = s.xrw;
    exp_q.push_back(s.e);
  endtask

  task automatic test_reset;
    stim_t s[$];
    exp_t  e;
    s.push_back(rst_row());
    s.push_back(mk(0, 0, 0, 32'h100, 1, 2, 3, 1, 1, ALU, 0, 0, 0, 1, ALU, 3, 2'b00, 2'b00, 32'h100));
    foreach (s[i]) begin
      apply(s[i]);
      #1;
      if (s[i].st !== 1'bx) begin
        vecs++;
        if (bus.stall_o !== s[i].st) begin
          fails++; $display("FAIL reset.stall[%0d] got %b want %b", i, bus.stall_o, s[i].st);
        end
      end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      vecs++;
      if ({bus.ctrl_o, bus.rd_addr_o, bus.fwd_a_o, bus.fwd_b_o} !== {e.ctrl, e.rd, e.fa, e.fb}) begin
        fails++; $display("FAIL reset.ctl[%0d] got %h/%0d/%b/%b want %h/%0d/%b/%b", i,
                          bus.ctrl_o, bus.rd_addr_o, bus.fwd_a_o, bus.fwd_b_o, e.ctrl, e.rd, e.fa, e.fb);
      end
      if (e.chk_pc) begin
        vecs++;
        if (bus.pc_o !== e.pc) begin
          fails++; $display("FAIL reset.pc[%0d] got %h want %h", i, bus.pc_o, e.pc);
        end
      end
      if (i == 0) begin
        vecs++;
        if ({bus.rs1_data_o, bus.rs2_data_o, bus.imm_o, bus.rs1_addr_o, bus.rs2_addr_o, bus.stall_o} !== '0) begin
          fails++; $display("FAIL reset.zero got %h %h %h %0d %0d %b want all zero", bus.rs1_data_o,
                            bus.rs2_data_o, bus.imm_o, bus.rs1_addr_o, bus.rs2_addr_o, bus.stall_o);
        end
      end
    end
    vecs++;
    if ({bus.rs1_data_o, bus.rs2_data_o, bus.imm_o, bus.rs1_addr_o, bus.rs2_addr_o} !==
        {32'h1111_0100, 32'h0000_2322, 32'hFFFF_FEFF, 5'd1, 5'd2}) begin
      fails++; $display("FAIL reset.data got %h %h %h %0d %0d want 11110100 00002322 fffffeff 1 2",
                        bus.rs1_data_o, bus.rs2_data_o, bus.imm_o, bus.rs1_addr_o, bus.rs2_addr_o);
    end
  endtask

  task automatic test_back_to_back;
    stim_t s[$];
    exp_t  e;
    // distance 1: add x5 ; sub x6,x5,x7
    s.push_back(rst_row());
    s.push_back(mk(0, 0, 0, 32'h200, 1, 2, 5, 1, 1, ALU, 0, 0, 0, 1, ALU, 5, 2'b00, 2'b00, 32'h200));
    s.push_back(mk(0, 0, 0, 32'h204, 5, 7, 6, 1, 1, ALU, 0, 0, 0, 1, ALU, 6, 2'b10, 2'b00, 32'h204));
    // distance 2: add x5 ; and x9 ; sub x6,x5,x7
    s.push_back(rst_row());
    s.push_back(mk(0, 0, 0, 32'h300, 1, 2, 5, 1, 1, ALU, 0, 0, 0, 1, ALU, 5, 2'b00, 2'b00, 32'h300));
    s.push_back(mk(0, 0, 0, 32'h304, 1, 2, 9, 1, 1, ALU, 0, 0, 0, 1, ALU, 9, 2'b00, 2'b00, 32'h304));
    s.push_back(mk(0, 0, 0, 32'h308, 5, 7, 6, 1, 1, ALU, 5, 1, 0, 1, ALU, 6, 2'b01, 2'b00, 32'h308));
    // both producers: or x5 ; add x5,x3,x4 ; sub x6,x5,x5 -> nearest wins
    s.push_back(rst_row());
    s.push_back(mk(0, 0, 0, 32'h400, 1, 2, 5, 1, 1, ALU, 0, 0, 0, 1, ALU, 5, 2'b00, 2'b00, 32'h400));
    s.push_back(mk(0, 0, 0, 32'h404, 3, 4, 5, 1, 1, ALU, 0, 0, 0, 1, ALU, 5, 2'b00, 2'b00, 32'h404));
    s.push_back(mk(0, 0, 0, 32'h408, 5, 5, 6, 1, 1, ALU, 5, 1, 0, 1, ALU, 6, 2'b10, 2'b10, 32'h408));
    foreach (s[i]) begin
      apply(s[i]);
      #1;
      if (s[i].st !== 1'bx) begin
        vecs++;
        if (bus.stall_o !== s[i].st) begin
          fails++; $display("FAIL b2b.stall[%0d] got %b want %b", i, bus.stall_o, s[i].st);
        end
      end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      vecs++;
      if ({bus.ctrl_o, bus.rd_addr_o, bus.fwd_a_o, bus.fwd_b_o} !== {e.ctrl, e.rd, e.fa, e.fb}) begin
        fails++; $display("FAIL b2b.ctl[%0d] got %h/%0d/%b/%b want %h/%0d/%b/%b", i,
                          bus.ctrl_o, bus.rd_addr_o, bus.fwd_a_o, bus.fwd_b_o, e.ctrl, e.rd, e.fa, e.fb);
      end
      if (e.chk_pc) begin
        vecs++;
        if (bus.pc_o !== e.pc) begin
          fails++; $display("FAIL b2b.pc[%0d] got %h want %h", i, bus.pc_o, e.pc);
        end
      end
    end
  endtask

  task automatic test_load_use;
    stim_t s[$];
    exp_t  e;
    // plain: lw x4 ; add x8,x4,x4 stalls once, then captures 01/01
    s.push_back(rst_row());
    s.push_back(mk(0, 0, 0, 32'h500, 1, 0, 4, 1, 0, LW, 0, 0, 0, 1, LW, 4, 2'b00, 2'b00, 32'h500));
    s.push_back(mk(0, 0, 0, 32'h504, 4, 4, 8, 1, 1, ALU, 0, 0, 1, 0, 8'h00, 0, 2'b00, 2'b00, 32'h0));
    s.push_back(mk(0, 0, 0, 32'h504, 4, 4, 8, 1, 1, ALU, 4, 1, 0, 1, ALU, 8, 2'b01, 2'b01, 32'h504));
    // stall visible under freeze, then stall together with flush: one bubble
    s.push_back(rst_row());
    s.push_back(mk(0, 0, 0, 32'h600, 1, 0, 4, 1, 0, LW, 0, 0, 0, 1, LW, 4, 2'b00, 2'b00, 32'h600));
    s.push_back(mk(0, 1, 0, 32'h604, 4, 4, 8, 1, 1, ALU, 0, 0, 1, 1, LW, 4, 2'b00, 2'b00, 32'h600));
    s.push_back(mk(0, 0, 1, 32'h604, 4, 4, 8, 1, 1, ALU, 0, 0, 1, 0, 8'h00, 0, 2'b00, 2'b00, 32'h0));
    s.push_back(mk(0, 0, 0, 32'h604, 4, 4, 8, 1, 1, ALU, 4, 1, 0, 1, ALU, 8, 2'b01, 2'b01, 32'h604));
    foreach (s[i]) begin
      apply(s[i]);
      #1;
      if (s[i].st !== 1'bx) begin
        vecs++;
        if (bus.stall_o !== s[i].st) begin
          fails++; $display("FAIL lduse.stall[%0d] got %b want %b", i, bus.stall_o, s[i].st);
        end
      end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      vecs++;
      if ({bus.ctrl_o, bus.rd_addr_o, bus.fwd_a_o, bus.fwd_b_o} !== {e.ctrl, e.rd, e.fa, e.fb}) begin
        fails++; $display("FAIL lduse.ctl[%0d] got %h/%0d/%b/%b want %h/%0d/%b/%b", i,
                          bus.ctrl_o, bus.rd_addr_o, bus.fwd_a_o, bus.fwd_b_o, e.ctrl, e.rd, e.fa, e.fb);
      end
      if (e.chk_pc) begin
        vecs++;
        if (bus.pc_o !== e.pc) begin
          fails++; $display("FAIL lduse.pc[%0d] got %h want %h", i, bus.pc_o, e.pc);
        end
      end
    end
  endtask

  task automatic test_x0_unused;
    stim_t s[$];
    exp_t  e;
    // lw x0 ; add x7,x0,x0 with EX/MEM also claiming x0 -> no stall, 00/00
    s.push_back(rst_row());
    s.push_back(mk(0, 0, 0, 32'h700, 1, 0, 0, 1, 0, LW, 0, 0, 0, 1, LW, 0, 2'b00, 2'b00, 32'h700));
    s.push_back(mk(0, 0, 0, 32'h704, 0, 0, 7, 1, 1, ALU, 0, 1, 0, 1, ALU, 7, 2'b00, 2'b00, 32'h704));
    // lw x4 ; consumer whose rs2 field is 4 but unused -> no stall, no forward
    s.push_back(rst_row());
    s.push_back(mk(0, 0, 0, 32'h710, 1, 0, 4, 1, 0, LW, 0, 0, 0, 1, LW, 4, 2'b00, 2'b00, 32'h710));
    s.push_back(mk(0, 0, 0, 32'h714, 1, 4, 9, 1, 0, ALU, 0, 0, 0, 1, ALU, 9, 2'b00, 2'b00, 32'h714));
    foreach (s[i]) begin
      apply(s[i]);
      #1;
      if (s[i].st !== 1'bx) begin
        vecs++;
        if (bus.stall_o !== s[i].st) begin
          fails++; $display("FAIL x0.stall[%0d] got %b want %b", i, bus.stall_o, s[i].st);
        end
      end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      vecs++;
      if ({bus.ctrl_o, bus.rd_addr_o, bus.fwd_a_o, bus.fwd_b_o} !== {e.ctrl, e.rd, e.fa, e.fb}) begin
        fails++; $display("FAIL x0.ctl[%0d] got %h/%0d/%b/%b want %h/%0d/%b/%b", i,
                          bus.ctrl_o, bus.rd_addr_o, bus.fwd_a_o, bus.fwd_b_o, e.ctrl, e.rd, e.fa, e.fb);
      end
      if (e.chk_pc) begin
        vecs++;
        if (bus.pc_o !== e.pc) begin
          fails++; $display("FAIL x0.pc[%0d] got %h want %h", i, bus.pc_o, e.pc);
        end
      end
    end
  endtask

  task automatic test_freeze;
    stim_t s[$];
    exp_t  e;
    s.push_back(rst_row());
    s.push_back(mk(0, 0, 0, 32'h800, 1, 2, 5, 1, 1, ALU, 0, 0, 0, 1, ALU, 5, 2'b00, 2'b00, 32'h800));
    for (int k = 0; k < 3; k++)
      s.push_back(mk(0, 1, 1, 32'h804, 5, 5, 6, 1, 1, ALU, 5, 1, 0, 1, ALU, 5, 2'b00, 2'b00, 32'h800));
    s.push_back(mk(0, 0, 1, 32'h804, 5, 5, 6, 1, 1, ALU, 5, 1, 0, 0, 8'h00, 0, 2'b00, 2'b00, 32'h0));
    s.push_back(mk(0, 0, 0, 32'h808, 1, 2, 5, 1, 1, ALU, 0, 0, 0, 1, ALU, 5, 2'b00, 2'b00, 32'h808));
    s.push_back(mk(1, 1, 0, 32'h80C, 5, 5, 6, 1, 1, ALU, 0, 0, 0, 1, 8'h00, 0, 2'b00, 2'b00, 32'h0));
    s.push_back(mk(0, 0, 0, 32'h810, 5, 1, 6, 1, 1, ALU, 0, 0, 0, 1, ALU, 6, 2'b00, 2'b00, 32'h810));
    foreach (s[i]) begin
      apply(s[i]);
      #1;
      if (s[i].st !== 1'bx) begin
        vecs++;
        if (bus.stall_o !== s[i].st) begin
          fails++; $display("FAIL freeze.stall[%0d] got %b want %b", i, bus.stall_o, s[i].st);
        end
      end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      vecs++;
      if ({bus.ctrl_o, bus.rd_addr_o, bus.fwd_a_o, bus.fwd_b_o} !== {e.ctrl, e.rd, e.fa, e.fb}) begin
        fails++; $display("FAIL freeze.ctl[%0d] got %h/%0d/%b/%b want %h/%0d/%b/%b", i,
                          bus.ctrl_o, bus.rd_addr_o, bus.fwd_a_o, bus.fwd_b_o, e.ctrl, e.rd, e.fa, e.fb);
      end
      if (e.chk_pc) begin
        vecs++;
        if (bus.pc_o !== e.pc) begin
          fails++; $display("FAIL freeze.pc[%0d] got %h want %h", i, bus.pc_o, e.pc);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load_use();
    test_x0_unused();
    test_freeze();
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard.drain got %0d entries left want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register for the 5-stage core, with precomputed forwarding selects and load-use hazard detection. It latches decode-stage operands and control, and emits the registered 2-bit forwarding selects consumed by the EX-stage operand muxes (00 register file, 10 EX/MEM result, 01 MEM/WB result). It also raises the load-use stall that holds PC and IF/ID and inserts a bubble into EX.

## Interface
- DATA_W, 32, datapath width
- REG_AW, 5, register index width
- CTRL_W, 8, control bundle width; bit map in shared package

- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- freeze_i  in  1  global pipeline hold (memory stall); register keeps contents
- flush_i  in  1  taken branch/jump; load a bubble
- pc_i  in  DATA_W  ID-stage PC
- rs1_data_i, rs2_data_i  in  DATA_W  register file read data (write-through RF)
- imm_i  in  DATA_W  sign-extended immediate
- rs1_addr_i, rs2_addr_i, rd_addr_i  in  REG_AW  ID-stage register indices
- use_rs1_i, use_rs2_i  in  1  ID instruction actually reads rs1/rs2
- ctrl_i  in  CTRL_W  decoded control bundle (RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, ALUOp)
- exmem_rd_i  in  REG_AW  EX/MEM destination
- exmem_regwrite_i  in  1  EX/MEM RegWrite
- pc_o, rs1_data_o, rs2_data_o, imm_o  out  DATA_W  registered copies
- rs1_addr_o, rs2_addr_o, rd_addr_o  out  REG_AW  registered copies
- ctrl_o  out  CTRL_W  registered control; all-zero = bubble
- fwd_a_o, fwd_b_o  out  2  registered forwarding selects for EX operands A/B
- stall_o  out  1  combinational load-use stall to PC/IF-ID

## Operation
- Load priority per cycle: rst_i > freeze_i (hold all) > flush_i or stall_o (bubble) > normal capture of ID inputs.
- Bubble: ctrl_o, fwd_a_o, fwd_b_o, rd_addr_o cleared. Data and address fields may capture ID inputs (don't-care).
- Load-use detect, combinational from current register state:
  - stall_o = ctrl_o.MemRead & ctrl_o.RegWrite & rd_addr_o != 0 & ((use_rs1_i & rs1_addr_i == rd_addr_o) | (use_rs2_i & rs2_addr_i == rd_addr_o)).
- Forward precompute for operand A, evaluated in ID and captured into fwd_a_o (B identical with rs2):
  - 10 if use_rs1_i & ctrl_o.RegWrite & rd_addr_o != 0 & rd_addr_o == rs1_addr_i. The producer now in EX is in EX/MEM next cycle.
  - else 01 if use_rs1_i & exmem_regwrite_i & exmem_rd_i != 0 & exmem_rd_i == rs1_addr_i. The producer is in MEM/WB next cycle.
  - else 00.
  - Nearest producer wins.
- Index 0 is never forwarded and never stalls.
- Distance-3 producers are covered by the write-through register file, not by this block.
- After a load-use stall, the re-presented consumer sees the bubble in ID/EX and the load in EX/MEM, so it captures 01.
- flush_i and stall_o together: single bubble, identical result.
- freeze_i with flush_i: freeze wins. The flush source keeps flush_i asserted until freeze drops.
- stall_o stays valid during freeze (pure function of held state and ID inputs).

## Timing
- One-cycle latency: ID inputs captured on the rising clk_i edge appear on outputs the same edge.
- rst_i sampled on clk_i. All registered outputs reset to 0, so stall_o = 0 after reset.
- Reset mid-operation discards the in-flight instruction. The next capture follows normal priority.
- stall_o has no register stage. The path is ID decode → compare → PC/IF-ID enable, within one cycle.

## Structure
- Package core_pkg holds:
  - CTRL_* bit indices for the control bundle.
  - FWD_RF=2'b00, FWD_EXMEM=2'b10, FWD_MEMWB=2'b01.
  - Width constants DATA_W and REG_AW.
- Sub-module fwd_precompute, instantiated twice (A and B): inputs src addr, use flag, ID/EX rd/RegWrite, EX/MEM rd/RegWrite; output 2-bit select.
- Hazard compare and pipeline register live in id_ex_stage.

## Test plan
- Reset: pulse rst_i with arbitrary inputs → all outputs 0, stall_o=0. Release and capture `add x3,x1,x2` → ctrl_o matches, fwd 00/00.
- Back-to-back ALU dependency: `add x5,..` then `sub x6,x5,x7` → second capture has fwd_a_o=10, fwd_b_o=00. Same with one independent instruction between → fwd_a_o=01.
- Both producers: `add x5` in EX and older `or x5` in EX/MEM, consumer reads x5 → fwd 10 (nearest).
- Load-use: `lw x4,0(x1)` then `add x8,x4,x4` → stall_o=1 for one cycle, bubble captured. Next cycle stall_o=0, consumer captured with fwd_a_o=fwd_b_o=01.
- x0 and unused sources: producer writes x0, consumer reads x0 → fwd 00, no stall. lw x4 followed by instruction with use_rs2_i=0 and rs2_addr_i=4 → no stall.
- freeze_i held 3 cycles with flush_i asserted → outputs unchanged throughout. Cycle after release → bubble. Reset asserted during freeze → outputs 0.
